// File: rtl/entry_pkg.sv
// Shared types for the switch-driven operand entry controller: FSM states,
// config field positions in the switch word and the default ALU flag width.
package entry_pkg;

  typedef enum logic [2:0] {
    ST_CONFIG = 3'd0,
    ST_OPA    = 3'd1,
    ST_OPB    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4,
    ST_FLAGS  = 3'd5
  } state_t;

  localparam int OPC_LSB        = 0;
  localparam int OPC_W          = 3;
  localparam int MODE_BIT       = 3;
  localparam int RND_BIT        = 4;
  localparam int FLAG_W_DEFAULT = 5;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debouncer; emits a one-cycle pulse on
// every accepted rising edge of the button level.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic evt
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level, so any bounce back to the old level restarts the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
      evt       <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      evt       <= 1'b0;
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
          evt       <= sync2_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/operand_entry_ctrl.sv
// Front panel controller: enters an ALU config and two operands chunk by chunk
// from switches, runs one ALU request and pages the result and flags on LEDs.
module operand_entry_ctrl
  import entry_pkg::*;
#(
  parameter int SW_W           = 16,
  parameter int DATA_W         = 32,
  parameter int HALF_W         = 16,
  parameter int DEB_CYCLES     = 1000000,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FLAG_W         = FLAG_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SW_W-1:0]   switches,
  input  logic              btn_next,
  input  logic              btn_back,
  output logic [SW_W-1:0]   leds,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [2:0]        op_code,
  output logic              mode_fp,
  output logic              round_mode,
  output logic              alu_start,
  input  logic              alu_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              busy
);

  localparam int NCH_MAX  = DATA_W / SW_W;
  localparam int NCH_HALF = HALF_W / SW_W;
  localparam int CHK_W    = (NCH_MAX > 1) ? $clog2(NCH_MAX) : 1;
  localparam int SPIN_W   = (SW_W > 1) ? $clog2(SW_W) : 1;
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state_reg;
  logic [CHK_W-1:0]    chk_reg;
  logic [CHK_W-1:0]    last_chk;
  logic [DATA_W-1:0]   result_reg;
  logic [FLAG_W-1:0]   flags_reg;
  logic                err_reg;
  logic [TMO_W-1:0]    tmo_reg;
  logic [19:0]         spin_div_reg;
  logic [SPIN_W-1:0]   spin_reg;
  logic [SW_W-1:0]     leds_next;
  logic [SW_W-1:0]     res_chunk [NCH_MAX];
  logic                next_evt;
  logic                back_evt;
  logic                next_only;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_next),
    .evt   (next_evt)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_back (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_back),
    .evt   (back_evt)
  );

  assign next_only = next_evt & ~back_evt;
  assign busy      = (state_reg == ST_WAIT);
  assign last_chk  = mode_fp ? CHK_W'(NCH_MAX - 1) : CHK_W'(NCH_HALF - 1);

  genvar gi;
  generate
    for (gi = 0; gi < NCH_MAX; gi++) begin : g_res_chunk
      assign res_chunk[gi] = result_reg[gi*SW_W +: SW_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_CONFIG;
      chk_reg    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
      mode_fp    <= 1'b0;
      round_mode <= 1'b0;
      alu_start  <= 1'b0;
      result_reg <= '0;
      flags_reg  <= '0;
      err_reg    <= 1'b0;
      tmo_reg    <= '0;
    end else begin
      case (state_reg)
        ST_CONFIG: begin
          if (next_only) begin
            op_code    <= switches[OPC_LSB +: OPC_W];
            mode_fp    <= switches[MODE_BIT];
            round_mode <= switches[RND_BIT];
            op_a       <= '0;
            op_b       <= '0;
            chk_reg    <= '0;
            state_reg  <= ST_OPA;
          end
        end
        ST_OPA: begin
          if (back_evt) begin
            if (chk_reg != '0) chk_reg <= chk_reg - 1'b1;
            else               state_reg <= ST_CONFIG;
          end else if (next_evt) begin
            for (int i = 0; i < NCH_MAX; i++)
              if (chk_reg == CHK_W'(i)) op_a[i*SW_W +: SW_W] <= switches;
            if (chk_reg != last_chk) begin
              chk_reg <= chk_reg + 1'b1;
            end else begin
              chk_reg   <= '0;
              state_reg <= ST_OPB;
            end
          end
        end
        ST_OPB: begin
          if (back_evt) begin
            if (chk_reg != '0) begin
              chk_reg <= chk_reg - 1'b1;
            end else begin
              chk_reg   <= last_chk;
              state_reg <= ST_OPA;
            end
          end else if (next_evt) begin
            for (int i = 0; i < NCH_MAX; i++)
              if (chk_reg == CHK_W'(i)) op_b[i*SW_W +: SW_W] <= switches;
            if (chk_reg != last_chk) begin
              chk_reg <= chk_reg + 1'b1;
            end else begin
              // Stale result/flags are dropped so a timeout shows only err.
              chk_reg    <= '0;
              state_reg  <= ST_WAIT;
              alu_start  <= 1'b1;
              tmo_reg    <= '0;
              result_reg <= '0;
              flags_reg  <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (alu_valid) begin
            result_reg <= alu_result;
            flags_reg  <= alu_flags;
            err_reg    <= 1'b0;
            alu_start  <= 1'b0;
            chk_reg    <= '0;
            state_reg  <= ST_RESULT;
          end else if (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            alu_start <= 1'b0;
            err_reg   <= 1'b1;
            chk_reg   <= '0;
            state_reg <= ST_FLAGS;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        ST_RESULT: begin
          if (back_evt) begin
            chk_reg   <= '0;
            state_reg <= ST_CONFIG;
          end else if (next_evt) begin
            if (chk_reg != last_chk) begin
              chk_reg <= chk_reg + 1'b1;
            end else begin
              chk_reg   <= '0;
              state_reg <= ST_FLAGS;
            end
          end
        end
        ST_FLAGS: begin
          if (back_evt || next_evt) begin
            chk_reg   <= '0;
            state_reg <= ST_CONFIG;
          end
        end
        default: begin
          chk_reg   <= '0;
          alu_start <= 1'b0;
          state_reg <= ST_CONFIG;
        end
      endcase
    end
  end

  // Free-running spinner shown while the ALU is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spin_div_reg <= '0;
      spin_reg     <= '0;
    end else begin
      spin_div_reg <= spin_div_reg + 1'b1;
      if (&spin_div_reg)
        spin_reg <= (spin_reg == SPIN_W'(SW_W - 1)) ? '0 : spin_reg + 1'b1;
    end
  end

  always_comb begin
    leds_next = '0;
    case (state_reg)
      ST_CONFIG:      leds_next[4:0] = {round_mode, mode_fp, op_code};
      ST_OPA, ST_OPB: leds_next = switches;
      ST_WAIT:        leds_next = SW_W'(1) << spin_reg;
      ST_RESULT:      leds_next = res_chunk[chk_reg];
      ST_FLAGS:       leds_next[FLAG_W:0] = {err_reg, flags_reg};
      default:        leds_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) leds <= '0;
    else        leds <= leds_next;
  end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Randomised bench for operand_entry_ctrl against a chunk-level behavioural model.
module tb_operand_entry_ctrl;

  localparam int SW_W   = 16;
  localparam int DATA_W = 32;
  localparam int HALF_W = 16;
  localparam int DEB    = 4;
  localparam int TMO    = 16;
  localparam int FLAG_W = 5;
  localparam int HOLD   = DEB + 6;

  logic              clk;
  logic              rst_n;
  logic [SW_W-1:0]   switches;
  logic              btn_next;
  logic              btn_back;
  logic [SW_W-1:0]   leds;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2:0]        op_code;
  logic              mode_fp;
  logic              round_mode;
  logic              alu_start;
  logic              alu_valid;
  logic [DATA_W-1:0] alu_result;
  logic [FLAG_W-1:0] alu_flags;
  logic              busy;

  operand_entry_ctrl #(
    .SW_W(SW_W), .DATA_W(DATA_W), .HALF_W(HALF_W),
    .DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .FLAG_W(FLAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .switches(switches),
    .btn_next(btn_next), .btn_back(btn_back), .leds(leds),
    .op_a(op_a), .op_b(op_b), .op_code(op_code), .mode_fp(mode_fp),
    .round_mode(round_mode), .alu_start(alu_start), .alu_valid(alu_valid),
    .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {M_CONFIG, M_OPA, M_OPB, M_WAIT, M_RESULT, M_FLAGS} mstate_t;

  mstate_t     m_state;
  int          m_chk;
  logic [15:0] m_a [2];
  logic [15:0] m_b [2];
  logic [2:0]  m_opc;
  logic        m_fp;
  logic        m_rnd;
  logic [31:0] m_res;
  logic [4:0]  m_flags;
  logic        m_err;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int nchunk();
    return m_fp ? DATA_W / SW_W : HALF_W / SW_W;
  endfunction

  function automatic logic [31:0] exp_a();
    return {m_a[1], m_a[0]};
  endfunction

  function automatic logic [31:0] exp_b();
    return {m_b[1], m_b[0]};
  endfunction

  function automatic logic [15:0] exp_leds();
    case (m_state)
      M_CONFIG: return {11'b0, m_rnd, m_fp, m_opc};
      M_OPA, M_OPB: return switches;
      M_WAIT: return 16'h0001;
      M_RESULT: return (m_chk == 0) ? m_res[15:0] : m_res[31:16];
      default: return {10'b0, m_err, m_flags};
    endcase
  endfunction

  task automatic model_reset();
    m_state = M_CONFIG; m_chk = 0;
    m_a[0] = '0; m_a[1] = '0; m_b[0] = '0; m_b[1] = '0;
    m_opc = '0; m_fp = 1'b0; m_rnd = 1'b0;
    m_res = '0; m_flags = '0; m_err = 1'b0;
  endtask

  task automatic model_next(input logic [15:0] sw);
    case (m_state)
      M_CONFIG: begin
        m_opc = sw[2:0]; m_fp = sw[3]; m_rnd = sw[4];
        m_a[0] = '0; m_a[1] = '0; m_b[0] = '0; m_b[1] = '0;
        m_chk = 0; m_state = M_OPA;
      end
      M_OPA: begin
        m_a[m_chk] = sw;
        if (m_chk < nchunk() - 1) m_chk++;
        else begin m_chk = 0; m_state = M_OPB; end
      end
      M_OPB: begin
        m_b[m_chk] = sw;
        if (m_chk < nchunk() - 1) m_chk++;
        else begin m_chk = 0; m_state = M_WAIT; m_res = '0; m_flags = '0; end
      end
      M_RESULT: begin
        if (m_chk < nchunk() - 1) m_chk++;
        else begin m_chk = 0; m_state = M_FLAGS; end
      end
      M_FLAGS: begin m_chk = 0; m_state = M_CONFIG; end
      default: ;
    endcase
  endtask

  task automatic model_back();
    case (m_state)
      M_OPA: if (m_chk > 0) m_chk--; else m_state = M_CONFIG;
      M_OPB: if (m_chk > 0) m_chk--; else begin m_state = M_OPA; m_chk = nchunk() - 1; end
      M_RESULT, M_FLAGS: begin m_chk = 0; m_state = M_CONFIG; end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, "_op_a"}, op_a, exp_a());
    check({tag, "_op_b"}, op_b, exp_b());
    check({tag, "_cfg"}, {27'b0, round_mode, mode_fp, op_code}, {27'b0, m_rnd, m_fp, m_opc});
    check({tag, "_busy"}, {31'b0, busy}, {31'b0, m_state == M_WAIT});
    check({tag, "_start"}, {31'b0, alu_start}, {31'b0, m_state == M_WAIT});
    check({tag, "_leds"}, {16'b0, leds}, {16'b0, exp_leds()});
  endtask

  task automatic press(input logic nxt, input logic bck);
    btn_next = nxt; btn_back = bck;
    repeat (HOLD) @(negedge clk);
    btn_next = 1'b0; btn_back = 1'b0;
    repeat (HOLD) @(negedge clk);
    if (bck) model_back();
    else if (nxt) model_next(switches);
  endtask

  task automatic do_next(input logic [15:0] sw);
    switches = sw;
    press(1'b1, 1'b0);
    $display("next sw=%h state=%s chk=%0d leds=%h", sw, m_state.name(), m_chk, leds);
    check_all("next");
  endtask

  task automatic do_back();
    press(1'b0, 1'b1);
    $display("back state=%s chk=%0d leds=%h", m_state.name(), m_chk, leds);
    check_all("back");
  endtask

  task automatic do_both();
    press(1'b1, 1'b1);
    $display("both state=%s chk=%0d leds=%h", m_state.name(), m_chk, leds);
    check_all("both");
  endtask

  // Final operand chunk: enter WAIT and answer the request after d cycles.
  task automatic go_alu(input logic [15:0] sw, input int d, input logic [31:0] res,
                        input logic [4:0] flg);
    int k;
    int hi;
    switches = sw;
    btn_next = 1'b1;
    k = 0;
    while (!alu_start && k < 40) begin @(negedge clk); k++; end
    check("alu_start_rise", {31'b0, alu_start}, 32'd1);
    model_next(sw);
    check("wait_busy", {31'b0, busy}, 32'd1);
    check("wait_op_a", op_a, exp_a());
    check("wait_op_b", op_b, exp_b());
    hi = 0; k = 0;
    while (alu_start && k < 40) begin
      hi++;
      if (k == 1) check("spinner", {16'b0, leds}, 32'd1);
      if (k == d) begin alu_result = res; alu_flags = flg; alu_valid = 1'b1; end
      else alu_valid = 1'b0;
      @(negedge clk);
      k++;
    end
    alu_valid = 1'b0;
    m_chk = 0;
    if (d < TMO) begin
      m_state = M_RESULT; m_res = res; m_flags = flg; m_err = 1'b0;
      check("start_len", hi, d + 1);
    end else begin
      m_state = M_FLAGS; m_err = 1'b1;
      check("start_len", hi, TMO);
    end
    btn_next = 1'b0;
    repeat (HOLD) @(negedge clk);
    $display("alu d=%0d res=%h flags=%h start_cycles=%0d state=%s leds=%h",
             d, res, flg, hi, m_state.name(), leds);
    check_all("alu");
  endtask

  function automatic int pick_delay();
    case ($urandom_range(0, 5))
      0, 1, 2: return $urandom_range(0, 6);
      3:       return TMO - 1;
      4:       return TMO;
      default: return TMO + 8;
    endcase
  endfunction

  initial begin
    int r;
    int steps;
    rst_n = 1'b0; switches = '0; btn_next = 1'b0; btn_back = 1'b0;
    alu_valid = 1'b0; alu_result = '0; alu_flags = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full-precision op=001, result paged LSB chunk first.
    do_next(16'h0009);
    do_next(16'h3C00);
    do_next(16'h0000);
    do_next(16'h4000);
    check("fp_op_a", op_a, 32'h00003C00);
    go_alu(16'h0000, 3, 32'h12345678, 5'h0A);
    check("fp_op_b", op_b, 32'h00004000);
    check("res_lo", {16'b0, leds}, 32'h00005678);
    do_next(16'h0000);
    check("res_hi", {16'b0, leds}, 32'h00001234);
    do_next(16'h0000);
    check("flags_ok", {16'b0, leds}, 32'h0000000A);
    do_next(16'h0000);

    // Reduced precision with ALU timeout.
    do_next(16'h0001);
    do_next(16'h3C00);
    go_alu(16'h4000, TMO + 8, 32'hDEADBEEF, 5'h1F);
    check("half_op_a", op_a, 32'h00003C00);
    check("timeout_leds", {16'b0, leds}, 32'h00000020);
    do_next(16'h0000);

    // Bouncing button must not advance; then back and rewrite an operand chunk.
    do_next(16'h0008);
    do_next(16'h1111);
    switches = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      btn_next = 1'b1; repeat (2) @(negedge clk);
      btn_next = 1'b0; repeat (2) @(negedge clk);
    end
    repeat (HOLD) @(negedge clk);
    $display("bounce state=%s chk=%0d op_a=%h", m_state.name(), m_chk, op_a);
    check_all("bounce");
    do_next(16'h2222);
    do_next(16'h5555);
    do_back();
    do_next(16'hABCD);
    check("rewrite_op_b", {16'b0, op_b[15:0]}, 32'h0000ABCD);
    check("rewrite_op_a", op_a, 32'h22221111);

    // Reset while waiting on the ALU; a late alu_valid is ignored.
    switches = 16'h7777;
    btn_next = 1'b1;
    steps = 0;
    while (!alu_start && steps < 40) begin @(negedge clk); steps++; end
    check("rst_wait_entry", {31'b0, alu_start}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0; btn_next = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    alu_result = 32'hCAFEF00D; alu_flags = 5'h15; alu_valid = 1'b1;
    @(negedge clk);
    alu_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("reset_in_wait leds=%h busy=%b", leds, busy);
    check_all("rst_wait");
    check("rst_leds", {16'b0, leds}, 32'd0);

    // Random walk through the state machine.
    for (int op = 0; op < 14; op++) begin
      do_next(16'($urandom));
      steps = 0;
      while (m_state != M_CONFIG && steps < 30) begin
        r = $urandom_range(0, 9);
        if (m_state == M_OPB && m_chk == nchunk() - 1 && r >= 3)
          go_alu(16'($urandom), pick_delay(), $urandom, 5'($urandom));
        else if (r < 2) do_back();
        else if (r == 2) do_both();
        else do_next(16'($urandom));
        steps++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_entry_ctrl.md
OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

Interface
REQ-001 SHALL have parameter SW_W, default 16, meaning switch/LED width and chunk width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning full-precision operand/result width, an integer multiple of SW_W.
REQ-003 SHALL have parameter HALF_W, default 16, meaning reduced-precision operand width, an integer multiple of SW_W and <= DATA_W.
REQ-004 SHALL have parameter DEB_CYCLES, default 1000000, meaning stable cycles before a button change is accepted.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum wait for alu_valid.
REQ-006 SHALL have parameter FLAG_W, default 5, meaning ALU flag width.
REQ-007 Ports (one clock; reset is asynchronous and active-low): clk  in  1  system clock; rst_n  in  1  async active-low reset.
REQ-008 switches  in  SW_W  config/operand chunk entry; btn_next  in  1  raw advance button; btn_back  in  1  raw step-back button.
REQ-009 leds  out  SW_W  display; op_a, op_b  out  DATA_W  captured operands; op_code  out  3; mode_fp  out  1; round_mode  out  1.
REQ-010 alu_start  out  1  request; alu_valid  in  1  ALU done; alu_result  in  DATA_W; alu_flags  in  FLAG_W; busy  out  1  high in WAIT.

Function
REQ-011 Each button SHALL be 2-FF synchronised, then debounced: the level is accepted after DEB_CYCLES consecutive stable samples; the counter clears on any mismatch.
REQ-012 A one-cycle next_evt/back_evt SHALL fire on each accepted rising edge; if both fire in one cycle, back_evt wins.
REQ-013 NCHUNK SHALL be DATA_W/SW_W when mode_fp=1, else HALF_W/SW_W; chunk index chk counts 0..NCHUNK-1, LSB chunk first.
REQ-014 States: CONFIG, OPA, OPB, WAIT, RESULT, FLAGS.
REQ-015 CONFIG + next_evt: latch op_code=switches[2:0], mode_fp=switches[3], round_mode=switches[4]; clear op_a, op_b; go OPA, chk=0.
REQ-016 OPA/OPB + next_evt: write switches into chunk chk of the operand; if chk<NCHUNK-1, chk++; else go OPB (from OPA) or WAIT (from OPB), chk=0.
REQ-017 In reduced mode, operand bits above HALF_W SHALL be zero.
REQ-018 back_evt: OPA/OPB with chk>0 gives chk--; OPA chk=0 goes CONFIG; OPB chk=0 goes OPA chk=NCHUNK-1; RESULT/FLAGS go CONFIG; ignored in CONFIG and WAIT.
REQ-019 alu_start SHALL assert on the cycle WAIT is entered and hold until the cycle after alu_valid is sampled high; operands SHALL be stable throughout.
REQ-020 WAIT + alu_valid: capture result and flags into internal registers, clear err, go RESULT chk=0 on the next cycle.
REQ-021 WAIT with no alu_valid for TIMEOUT_CYCLES cycles: drop alu_start, set err=1, go FLAGS.
REQ-022 Button events in WAIT SHALL be discarded.
REQ-023 RESULT + next_evt: chk++ up to NCHUNK-1, then go FLAGS; FLAGS + next_evt goes CONFIG.
REQ-024 leds: CONFIG shows the latched config in bits [4:0]; OPA/OPB show switches; WAIT shows 1<<chk_spinner, where chk_spinner rotates over SW_W positions once every 2^20 cycles; RESULT shows result chunk chk; FLAGS shows {err, flags} zero-extended.
REQ-025 Captured result and flags SHALL persist until the next WAIT entry.
REQ-026 A mode change SHALL take effect only at the CONFIG latch.

Reset
REQ-027 On rst_n low, asynchronously: state=CONFIG, chk=0, every output register 0, leds=0, debouncers cleared, err=0, alu_start=0.
REQ-028 A reset asserted in any state, including WAIT, SHALL abort the operation; a later alu_valid SHALL be ignored outside WAIT.

Structure
REQ-029 The state enum, the op_code field positions and the FLAG_W default SHALL reside in shared package entry_pkg.
REQ-030 The debounce+edge logic SHALL be one sub-module, btn_debounce (parameter DEB_CYCLES), instantiated twice.
REQ-031 The ALU SHALL NOT be instantiated inside the block; it is connected at board top.

Verification (DEB_CYCLES=4, TIMEOUT_CYCLES=16)
REQ-032 Single mode, op=001: chunks A=3C00,0000 and B=4000,0000 -> op_a=00003C00, op_b=00004000, alu_start held until valid; result 12345678 -> leds 5678 then 1234 then flags.
REQ-033 Half mode: one chunk per operand (3C00, 4000) -> op_a=00003C00, WAIT reached after two next events.
REQ-034 Bounce: toggling btn_next every 2 cycles for 20 cycles -> no state change; stable high 4+ cycles -> exactly one advance.
REQ-035 Timeout: alu_valid never asserted -> alu_start deasserts after 16 cycles; FLAGS leds = {err=1, 00000}.
REQ-036 back_evt in OPB chunk 1 -> chk=0; rewrite chunk 0 = ABCD -> op_b[15:0]=ABCD, with op_a unchanged.
REQ-037 rst_n low mid-WAIT, then alu_valid pulse -> state CONFIG, leds=0, captured result unchanged (0).
